// File: rtl/ela_mem_arb_pkg.sv
// Shared constants and types for the ELA frame-memory arbiter.
// Frame geometry is 128 x 64 pixels, one 8-bit pixel per memory word.
`timescale 1ns/1ps
package ela_pkg;

  localparam int IMG_W       = 128;
  localparam int IMG_H       = 64;
  localparam int AW          = 13;
  localparam int DW          = 8;
  localparam int FRAME_WORDS = IMG_W * IMG_H;
  localparam int CNT_W       = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_RET
  } state_e;

endpackage

// File: rtl/ela_mem_arb_if.sv
// Bundle of the write port, read port, RAM port and frame status of the arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the RAM.
`timescale 1ns/1ps
interface ela_mem_arb_if #(
  parameter int AW = ela_pkg::AW,
  parameter int DW = ela_pkg::DW
);

  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_gnt;

  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_gnt;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          frame_clr;
  logic          frame_done;

  modport slave (
    input  w_req, w_addr, w_data, r_req, r_addr, mem_rdata, frame_clr,
    output w_gnt, r_gnt, r_rvalid, r_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, frame_done
  );

  modport master (
    output w_req, w_addr, w_data, r_req, r_addr, mem_rdata, frame_clr,
    input  w_gnt, r_gnt, r_rvalid, r_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, frame_done
  );

endinterface

// File: rtl/ela_mem_arb_rr_arb2.sv
// Two-way round-robin picker: a tie goes to the side that was not granted last.
// pick_o is one-hot, bit 0 = write side, bit 1 = read side.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic       req_w_i,
  input  logic       req_r_i,
  input  logic       last_r_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = 2'b00;
    if (req_w_i && req_r_i) begin
      pick_o = last_r_i ? 2'b01 : 2'b10;
    end else if (req_w_i) begin
      pick_o = 2'b01;
    end else if (req_r_i) begin
      pick_o = 2'b10;
    end
  end

endmodule

// File: rtl/ela_mem_arb.sv
// Arbiter sharing one single-port frame RAM between the ELA write engine and a host reader.
// Optional ELA_ARB_RD_BLOCK_EN: host reads are held off until a full frame has been written.
`timescale 1ns/1ps
module ela_mem_arb #(
  parameter int AW          = ela_pkg::AW,
  parameter int DW          = ela_pkg::DW,
  parameter int FRAME_WORDS = ela_pkg::FRAME_WORDS
) (
  input logic          clk,
  input logic          rst,
  ela_mem_arb_if.slave arb_if
);

  import ela_pkg::*;

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);

  state_e         state_q;
  logic           last_r_q;
  logic           w_gnt_q;
  logic           r_gnt_q;
  logic           r_rvalid_q;
  logic           mem_en_q;
  logic           mem_we_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;
  logic           frame_done_q;
  logic           frame_done_d;
  logic           r_req_ok;
  logic [1:0]     pick;

`ifdef ELA_ARB_RD_BLOCK_EN
  assign r_req_ok = arb_if.r_req & frame_done_q;
`else
  assign r_req_ok = arb_if.r_req;
`endif

  rr_arb2 u_rr_arb2 (
    .req_w_i  (arb_if.w_req),
    .req_r_i  (r_req_ok),
    .last_r_i (last_r_q),
    .pick_o   (pick)
  );

  // A clear wins over a write in the same cycle, so that write is not counted.
  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    frame_done_d = frame_done_q;
    if (arb_if.frame_clr) begin
      wr_cnt_d     = '0;
      frame_done_d = 1'b0;
    end else begin
      if ((state_q == ST_WR) && (wr_cnt_q != FRAME_CNT)) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      if (wr_cnt_d == FRAME_CNT) begin
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_r_q     <= 1'b1;
      w_gnt_q      <= 1'b0;
      r_gnt_q      <= 1'b0;
      r_rvalid_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      frame_done_q <= frame_done_d;
      w_gnt_q      <= 1'b0;
      r_gnt_q      <= 1'b0;
      r_rvalid_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick[0]) begin
            state_q     <= ST_WR;
            last_r_q    <= 1'b0;
            w_gnt_q     <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= arb_if.w_addr;
            mem_wdata_q <= arb_if.w_data;
          end else if (pick[1]) begin
            state_q    <= ST_RD;
            last_r_q   <= 1'b1;
            r_gnt_q    <= 1'b1;
            mem_en_q   <= 1'b1;
            mem_addr_q <= arb_if.r_addr;
          end
        end
        ST_WR:     state_q <= ST_IDLE;
        ST_RD: begin
          state_q    <= ST_RD_RET;
          r_rvalid_q <= 1'b1;
        end
        ST_RD_RET: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign arb_if.w_gnt      = w_gnt_q;
  assign arb_if.r_gnt      = r_gnt_q;
  assign arb_if.r_rvalid   = r_rvalid_q;
  assign arb_if.mem_en     = mem_en_q;
  assign arb_if.mem_we     = mem_we_q;
  assign arb_if.mem_addr   = mem_addr_q;
  assign arb_if.mem_wdata  = mem_wdata_q;
  assign arb_if.frame_done = frame_done_q;

  // The RAM output is already a register; gating it keeps r_rdata at zero outside r_rvalid.
  assign arb_if.r_rdata = r_rvalid_q ? arb_if.mem_rdata : '0;

endmodule

// File: tb/tb_ela_mem_arb.sv
// Self-checking bench for ela_mem_arb with a behavioural single-port RAM (1-cycle read).
// Scoreboard queues hold expected grant order and read data, popped when the DUT answers.
`timescale 1ns/1ps
module tb_ela_mem_arb;

  import ela_pkg::*;

  typedef struct packed {
    logic       is_r;
    logic [7:0] cyc;
  } gnt_exp_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int fails  = 0;
  bit rgnt_seen;

  logic [DW-1:0] rd_exp_q[$];
  gnt_exp_t      gnt_q[$];

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_rdata_q;

  always #5 clk = ~clk;

  ela_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  ela_mem_arb #(.AW(AW), .DW(DW), .FRAME_WORDS(FRAME_WORDS)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rdata_q       <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rdata_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.w_req     = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.r_req     = 1'b0;
    bus.r_addr    = '0;
    bus.frame_clr = 1'b0;
  endtask

  // Issues one write and returns in the cycle after its WR cycle.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit clr_on_gnt, output bit ok);
    ok         = 1'b0;
    bus.w_req  = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    for (int i = 0; i < 8 && !ok; i++) begin
      step();
      if (bus.r_gnt) rgnt_seen = 1'b1;
      if (bus.w_gnt) ok = 1'b1;
    end
    bus.w_req = 1'b0;
    if (ok && clr_on_gnt) bus.frame_clr = 1'b1;
    step();
    bus.frame_clr = 1'b0;
    if (bus.r_gnt) rgnt_seen = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    drive_idle();
    rst = 1'b1;
    step();
    step();
    flags = {bus.w_gnt, bus.r_gnt, bus.r_rvalid, bus.mem_en, bus.mem_we, bus.frame_done};
    checks++;
    if (flags !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", flags);
    end
    checks++;
    if (bus.mem_addr !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata);
    end
    checks++;
    if (bus.r_rdata !== '0) begin
      fails++;
      $display("[TB] FAIL reset_r_rdata: got %h expected 0", bus.r_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    logic [4:0] flags;
    bus.w_req  = 1'b1;
    bus.w_addr = 13'h0085;
    bus.w_data = 8'h3C;
    step();
    flags = {bus.w_gnt, bus.mem_en, bus.mem_we, bus.r_gnt, bus.r_rvalid};
    checks++;
    if (flags !== 5'b11100) begin
      fails++;
      $display("[TB] FAIL write_flags: got %b expected 11100", flags);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {13'h0085, 8'h3C}) begin
      fails++;
      $display("[TB] FAIL write_bus: got addr %h data %h expected addr 0085 data 3c",
               bus.mem_addr, bus.mem_wdata);
    end
    bus.w_req = 1'b0;
    step();
    flags = {bus.w_gnt, bus.mem_en, bus.mem_we, bus.r_gnt, bus.r_rvalid};
    checks++;
    if (flags !== 5'b00000) begin
      fails++;
      $display("[TB] FAIL write_idle_flags: got %b expected 00000", flags);
    end
    checks++;
    if (ram[13'h0085] !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL write_ram: got %h expected 3c", ram[13'h0085]);
    end
  endtask

  task automatic test_frame_count();
    bit ok;
    int timeouts = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < FRAME_WORDS - 1; i++) begin
      do_write(AW'(i), DW'(i), 1'b0, ok);
      if (!ok) timeouts++;
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_before_last: got %b expected 0", bus.frame_done);
    end
    do_write(AW'(FRAME_WORDS - 1), 8'hFF, 1'b0, ok);
    if (!ok) timeouts++;
    checks++;
    if (bus.frame_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL frame_done_set: got %b expected 1", bus.frame_done);
    end
    do_write(13'h0005, 8'hE1, 1'b0, ok);
    checks++;
    if ({ok, bus.frame_done, ram[13'h0005]} !== {1'b1, 1'b1, 8'hE1}) begin
      fails++;
      $display("[TB] FAIL frame_extra_write: got gnt %b done %b ram %h expected 1 1 e1",
               ok, bus.frame_done, ram[13'h0005]);
    end
    do_write(13'h0006, 8'h5A, 1'b1, ok);
    checks++;
    if ({ok, bus.frame_done, ram[13'h0006]} !== {1'b1, 1'b0, 8'h5A}) begin
      fails++;
      $display("[TB] FAIL frame_clr_write: got gnt %b done %b ram %h expected 1 0 5a",
               ok, bus.frame_done, ram[13'h0006]);
    end
    for (int i = 0; i < FRAME_WORDS - 1; i++) begin
      do_write(AW'(i), DW'(i + 3), 1'b0, ok);
      if (!ok) timeouts++;
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL frame_after_clr_early: got %b expected 0", bus.frame_done);
    end
    do_write(AW'(FRAME_WORDS - 1), 8'h11, 1'b0, ok);
    if (!ok) timeouts++;
    checks++;
    if (bus.frame_done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL frame_after_clr_done: got %b expected 1", bus.frame_done);
    end
    checks++;
    if (timeouts !== 0) begin
      fails++;
      $display("[TB] FAIL frame_write_timeouts: got %0d expected 0", timeouts);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int lat = 0;
    logic [DW-1:0] exp_d;
    do_write(13'h1FFF, 8'hA5, 1'b0, ok);
    rd_exp_q.push_back(8'hA5);
    bus.r_req  = 1'b1;
    bus.r_addr = 13'h1FFF;
    step();
    checks++;
    if ({bus.r_gnt, bus.mem_en, bus.mem_we, bus.r_rvalid, bus.mem_addr} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 13'h1FFF}) begin
      fails++;
      $display("[TB] FAIL read_gnt: got gnt %b en %b we %b rv %b addr %h expected 1 1 0 0 1fff",
               bus.r_gnt, bus.mem_en, bus.mem_we, bus.r_rvalid, bus.mem_addr);
    end
    bus.r_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      lat++;
      if (bus.r_rvalid) break;
    end
    exp_d = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 8'h00;
    checks++;
    if ({bus.r_rvalid, bus.r_rdata} !== {1'b1, exp_d}) begin
      fails++;
      $display("[TB] FAIL read_data: got rvalid %b data %h expected 1 %h",
               bus.r_rvalid, bus.r_rdata, exp_d);
    end
    checks++;
    if (lat !== 1) begin
      fails++;
      $display("[TB] FAIL read_latency: got %0d expected 1 cycle after r_gnt", lat);
    end
    step();
    checks++;
    if ({bus.r_rvalid, bus.mem_en, bus.r_gnt, bus.r_rdata} !== {3'b000, 8'h00}) begin
      fails++;
      $display("[TB] FAIL read_pulse_end: got rv %b en %b gnt %b data %h expected 0 0 0 00",
               bus.r_rvalid, bus.mem_en, bus.r_gnt, bus.r_rdata);
    end
  endtask

  task automatic test_contention();
    int cyc = 0;
    int ngnt = 0;
    int nrv = 0;
    gnt_exp_t e;
    logic [DW-1:0] exp_d;
    gnt_q.push_back({1'b0, 8'd1});
    gnt_q.push_back({1'b1, 8'd3});
    gnt_q.push_back({1'b0, 8'd6});
    gnt_q.push_back({1'b1, 8'd8});
    rd_exp_q.push_back(8'h77);
    rd_exp_q.push_back(8'h77);
    bus.w_req  = 1'b1;
    bus.w_addr = 13'h0010;
    bus.w_data = 8'h77;
    bus.r_req  = 1'b1;
    bus.r_addr = 13'h0010;
    while (cyc < 30 && (ngnt < 4 || nrv < 2)) begin
      step();
      cyc++;
      if (bus.w_gnt || bus.r_gnt) begin
        ngnt++;
        e = (gnt_q.size() > 0) ? gnt_q.pop_front() : {1'b0, 8'd0};
        checks++;
        if ({bus.r_gnt, bus.w_gnt, 8'(cyc)} !== {e.is_r, !e.is_r, e.cyc}) begin
          fails++;
          $display("[TB] FAIL contention_grant%0d: got r %b w %b at cycle %0d expected r %b at cycle %0d",
                   ngnt, bus.r_gnt, bus.w_gnt, cyc, e.is_r, e.cyc);
        end
        if (ngnt == 4) begin
          bus.w_req = 1'b0;
          bus.r_req = 1'b0;
        end
      end
      if (bus.r_rvalid) begin
        nrv++;
        exp_d = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 8'hXX;
        checks++;
        if (bus.r_rdata !== exp_d) begin
          fails++;
          $display("[TB] FAIL contention_rdata%0d: got %h expected %h", nrv, bus.r_rdata, exp_d);
        end
      end
    end
    checks++;
    if (ngnt !== 4 || nrv !== 2) begin
      fails++;
      $display("[TB] FAIL contention_count: got %0d grants %0d rvalids expected 4 and 2", ngnt, nrv);
    end
    gnt_q.delete();
    rd_exp_q.delete();
    step();
  endtask

  task automatic test_reset_in_read();
    int nrv = 0;
    logic [5:0] flags;
    bus.r_req  = 1'b1;
    bus.r_addr = 13'h0085;
    step();
    checks++;
    if (bus.r_gnt !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rstrd_gnt: got %b expected 1", bus.r_gnt);
    end
    rst       = 1'b1;
    bus.r_req = 1'b0;
    step();
    flags = {bus.w_gnt, bus.r_gnt, bus.r_rvalid, bus.mem_en, bus.mem_we, bus.frame_done};
    checks++;
    if ({flags, bus.mem_addr, bus.mem_wdata, bus.r_rdata} !== '0) begin
      fails++;
      $display("[TB] FAIL rstrd_outputs: got flags %b addr %h wdata %h rdata %h expected all 0",
               flags, bus.mem_addr, bus.mem_wdata, bus.r_rdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.r_rvalid) nrv++;
    end
    checks++;
    if (nrv !== 0) begin
      fails++;
      $display("[TB] FAIL rstrd_no_rvalid: got %0d rvalid pulses expected 0", nrv);
    end
  endtask

`ifdef ELA_ARB_RD_BLOCK_EN
  task automatic test_read_block();
    bit ok;
    int wait_cyc = 0;
    bit got = 1'b0;
    rgnt_seen  = 1'b0;
    bus.r_req  = 1'b1;
    bus.r_addr = 13'h0010;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.r_gnt) rgnt_seen = 1'b1;
    end
    checks++;
    if (rgnt_seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL block_idle_gnt: got r_gnt expected none");
    end
    for (int i = 0; i < FRAME_WORDS; i++) begin
      do_write(AW'(i), DW'(i), 1'b0, ok);
    end
    checks++;
    if ({rgnt_seen, bus.frame_done} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL block_fill: got rgnt_seen %b done %b expected 0 1", rgnt_seen, bus.frame_done);
    end
    while (wait_cyc < 2 && !got) begin
      step();
      wait_cyc++;
      if (bus.r_gnt) got = 1'b1;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL block_release: got no r_gnt expected one within 2 cycles");
    end
    bus.r_req = 1'b0;
    step();
    step();
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_frame_count();
    test_single_read();
    test_contention();
    test_reset_in_read();
`ifdef ELA_ARB_RD_BLOCK_EN
    test_read_block();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no end of test expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ela_mem_arb.md
ELA_MEM_ARB -- requirements
Module: ela_mem_arb

Interface
REQ-001 Parameter AW, 13, memory address width (128 x 64 pixel frame).
REQ-002 Parameter DW, 8, pixel width.
REQ-003 Parameter FRAME_WORDS, 8192, writes per complete frame.
REQ-004 Clock and reset: clk input 1, rising-edge clock; rst input 1, synchronous, active-high reset.
REQ-005 w_req input 1, write request from ELA engine; w_addr input AW; w_data input DW.
REQ-006 w_gnt output 1, one-cycle pulse marking the cycle the write is performed.
REQ-007 r_req input 1, read request from host; r_addr input AW.
REQ-008 r_gnt output 1, one-cycle pulse marking the read address cycle.
REQ-009 r_rvalid output 1, one-cycle pulse; r_rdata output DW, valid only while r_rvalid=1.
REQ-010 mem_en, mem_we output 1 each; mem_addr output AW; mem_wdata output DW; mem_rdata input DW (single-port RAM, 1-cycle read latency).
REQ-011 frame_clr input 1, clears frame counter; frame_done output 1, sticky frame-complete flag.

Function
REQ-012 FSM states IDLE, WR, RD, RD_RET; all outputs registered.
REQ-013 IDLE: no request -> IDLE; only w_req -> WR; only r_req (and read permitted) -> RD; both -> round-robin pick.
REQ-014 Round-robin: tie goes to the requester NOT granted most recently; the last-grant pointer updates on every grant.
REQ-015 WR, one cycle: mem_en=1, mem_we=1, mem_addr=w_addr, mem_wdata=w_data, w_gnt=1; next state IDLE.
REQ-016 RD, one cycle: mem_en=1, mem_we=0, mem_addr=r_addr, r_gnt=1; next state RD_RET.
REQ-017 RD_RET: r_rdata=mem_rdata, r_rvalid=1; next state IDLE.
REQ-018 Requester holds req, addr and data stable until it samples its gnt=1, then drops req; the arbiter never grants the same request twice.
REQ-019 Latency from req rising (IDLE, uncontended): write performed 1 cycle later; r_rvalid 2 cycles later.
REQ-020 Minimum spacing: 2 cycles per write, 3 cycles per read; with both requesters continuously requesting, each waits at most one foreign access.
REQ-021 14-bit write counter increments on each WR cycle and saturates at FRAME_WORDS.
REQ-022 frame_done is set on the cycle after the counter reaches FRAME_WORDS and remains set.
REQ-023 Further writes after saturation are still performed; the counter stays at FRAME_WORDS.
REQ-024 frame_clr clears the counter and frame_done. A write in the same cycle is performed but not counted.
REQ-025 mem_we=0 and mem_en=0 in IDLE and RD_RET.

Reset
REQ-026 rst: state IDLE; all gnt/valid/mem_en/mem_we = 0; mem_addr, mem_wdata, r_rdata = 0; counter = 0; frame_done = 0; last-grant pointer = R (first tie goes to W).
REQ-027 Reset during RD or RD_RET drops the read; no r_rvalid is issued.

Configuration
REQ-028 Macro ELA_ARB_RD_BLOCK_EN defined: r_req is ignored (never granted) while frame_done=0; the host reads only complete frames.
REQ-029 Macro ELA_ARB_RD_BLOCK_EN undefined: reads arbitrate freely regardless of frame_done.

Structure
REQ-030 Package ela_pkg holds AW, DW, FRAME_WORDS, image width/height constants (128/64) and the FSM state typedef.
REQ-031 Sub-module rr_arb2: combinational 2-way round-robin picker (inputs: two requests, last-grant pointer; output: one-hot pick); ela_mem_arb owns the pointer register.

Verification
REQ-032 Single write: w_req=1, w_addr=0x0085, w_data=0x3C in IDLE -> next cycle w_gnt=1, mem_we=1, mem_addr=0x0085, mem_wdata=0x3C.
REQ-033 Single read: r_req=1, r_addr=0x1FFF, RAM holds 0xA5 -> r_gnt one cycle later, r_rvalid=1 with r_rdata=0xA5 two cycles later (macro undefined, or frame_done=1).
REQ-034 Contention: w_req and r_req held high from reset -> grant order W, R, W, R; no requester waits more than one foreign access.
REQ-035 Frame count: 8192 writes -> frame_done=1 the cycle after the 8192nd WR; 8193rd write performed, frame_done stays 1; frame_clr -> frame_done=0, counter=0.
REQ-036 ELA_ARB_RD_BLOCK_EN defined: r_req held high with frame_done=0 -> no r_gnt; first r_gnt follows within 2 cycles of frame_done rising.
REQ-037 rst asserted in RD cycle -> next cycle all outputs at reset values and no r_rvalid ever issued for that read.
